// File: rtl/debouncer_pkg.sv
// -----------------------------------------------------------------------------
// debouncer_pkg
// Shared helpers for the multi-channel push-button debouncer.
//   clog2       : ceiling log2 used to size counters at elaboration time
//   cnt_width   : counter width for a range of 'count' values, never below 1 bit
//   idle_level  : raw pin level of a released button for a given polarity
// -----------------------------------------------------------------------------
package debouncer_pkg;

    // Narrowest legal counter; a zero-width vector cannot be declared.
    localparam int MIN_CNT_W   = 1;
    // Depth of the metastability synchroniser ahead of the stability counter.
    localparam int SYNC_STAGES = 2;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        for (rem = value - 1; rem > 0; rem = rem >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int cnt_width(input int count);
        return (clog2(count) < MIN_CNT_W) ? MIN_CNT_W : clog2(count);
    endfunction

    function automatic logic idle_level(input int active_low);
        return (active_low != 0);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One push-button channel: 2-FF synchroniser, stability counter advanced by the
// shared prescaler tick, debounced level with one-cycle press/release pulses
// and an optional long-press pulse.
// Build option: DEBOUNCER_LONGPRESS_EN enables the hold counter; when it is not
// defined the hold output is tied low.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous, active-high reset
//   tick    in  shared sample tick (one clk cycle wide)
//   pb_raw  in  raw asynchronous button pin
//   state   out debounced level, 1 = pressed
//   down    out one-cycle pulse on debounced press
//   up      out one-cycle pulse on debounced release
//   hold    out one-cycle pulse on long press
// -----------------------------------------------------------------------------
module debounce_channel
    import debouncer_pkg::*;
#(
    parameter int ACTIVE_LOW   = 1,
    parameter int STABLE_TICKS = 3,
    parameter int HOLD_TICKS   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic pb_raw,
    output logic state,
    output logic down,
    output logic up,
    output logic hold
);

    localparam int                CNT_W   = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_TICKS - 1);
    localparam logic              IDLE    = idle_level(ACTIVE_LOW);

    logic             sync_p0;
    logic             sync_p1;
    logic             pressed_s;
    logic [CNT_W-1:0] cnt;

    // ---- stage p0/p1: synchroniser, preset to the released pin level ----
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= IDLE;
            sync_p1 <= IDLE;
        end else begin
            sync_p0 <= pb_raw;
            sync_p1 <= sync_p0;
        end
    end

    assign pressed_s = sync_p1 ^ IDLE;

    // ---- stage p2: stability counter, debounced level and edge pulses ----
    // Any sample agreeing with the current level clears the count, so only an
    // uninterrupted run of STABLE_TICKS differing ticks flips the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            state <= 1'b0;
            down  <= 1'b0;
            up    <= 1'b0;
        end else begin
            down <= 1'b0;
            up   <= 1'b0;
            if (pressed_s == state) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CNT_MAX) begin
                    cnt   <= '0;
                    state <= ~state;
                    down  <= ~state;
                    up    <= state;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef DEBOUNCER_LONGPRESS_EN
    localparam int                HOLD_W   = clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_TICKS - 1);

    logic [HOLD_W-1:0] hold_cnt;

    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] value);
        return (value == HOLD_MAX) ? value : value + 1'b1;
    endfunction

    // ---- stage p3: long-press counter ----
    // Saturation at HOLD_TICKS keeps the pulse to a single one per press.
    always_ff @(posedge clk) begin
        if (rst || !state || down) begin
            hold_cnt <= '0;
            hold     <= 1'b0;
        end else begin
            hold <= 1'b0;
            if (tick) begin
                hold_cnt <= sat_inc(hold_cnt);
                hold     <= (hold_cnt == HOLD_PRE);
            end
        end
    end
`else
    // Keeps HOLD_TICKS referenced when the long-press logic is compiled out.
    logic unused_hold_cfg;
    assign unused_hold_cfg = (HOLD_TICKS > 0);
    assign hold            = 1'b0;
`endif

endmodule

// File: rtl/debouncer_multi.sv
// -----------------------------------------------------------------------------
// debouncer_multi
// N-channel push-button debouncer between the board buttons and the UART
// control/test logic. A single prescaler produces the sample tick shared by
// every channel; each channel is an independent debounce_channel instance.
// Build option: DEBOUNCER_LONGPRESS_EN enables long-press detection (PB_hold);
// without it PB_hold is constant 0 and the port list is unchanged.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous, active-high reset
//   PB        in  [N_CH] raw asynchronous button inputs
//   PB_state  out [N_CH] debounced level, 1 = pressed
//   PB_down   out [N_CH] one-cycle pulse on debounced press
//   PB_up     out [N_CH] one-cycle pulse on debounced release
//   PB_hold   out [N_CH] one-cycle pulse on long press
// -----------------------------------------------------------------------------
module debouncer_multi
    import debouncer_pkg::*;
#(
    parameter int N_CH         = 2,
    parameter int ACTIVE_LOW   = 1,
    parameter int TICK_DIV     = 4,
    parameter int STABLE_TICKS = 3,
    parameter int HOLD_TICKS   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] PB,
    output logic [N_CH-1:0] PB_state,
    output logic [N_CH-1:0] PB_down,
    output logic [N_CH-1:0] PB_up,
    output logic [N_CH-1:0] PB_hold
);

    localparam int                  PRESC_W   = cnt_width(TICK_DIV);
    localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;

    // With TICK_DIV=1 the counter sits at 0 == PRESC_MAX, so tick is constant 1.
    assign tick = (presc_cnt == PRESC_MAX);

    // ---- prescaler: 0..TICK_DIV-1, tick in the terminal-count cycle ----
    always_ff @(posedge clk) begin
        if (rst || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .ACTIVE_LOW   (ACTIVE_LOW),
            .STABLE_TICKS (STABLE_TICKS),
            .HOLD_TICKS   (HOLD_TICKS)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick),
            .pb_raw (PB[g]),
            .state  (PB_state[g]),
            .down   (PB_down[g]),
            .up     (PB_up[g]),
            .hold   (PB_hold[g])
        );
    end

endmodule
